// File: rtl/mem_access_stage.sv
// MEM stage with MEM/WB pipeline register: data-memory req/ack handshake, upstream stall, branch decision.
// Optional MEM_TIMEOUT_EN build aborts a WAIT after TIMEOUT_CYCLES cycles and raises a sticky mem_err.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     ALUResultin,
  input  logic [DATA_W-1:0]     RtDatain,
  input  logic [REG_ADDR_W-1:0] regwriteAddressin,
  input  logic [DATA_W-1:0]     BranchAddressin,
  input  logic                  ZeroFlagin,
  input  logic                  Branchin,
  input  logic                  MemtoRegin,
  input  logic                  RegWritein,
  input  logic                  MemReadin,
  input  logic                  MemWritein,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  pcSrc,
  output logic [DATA_W-1:0]     BranchAddress,
  output logic [DATA_W-1:0]     ReadData,
  output logic [DATA_W-1:0]     ALUResult,
  output logic [REG_ADDR_W-1:0] regwriteAddress,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0]     ZERO_D       = {DATA_W{1'b0}};
  localparam logic [REG_ADDR_W-1:0] ZERO_R       = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]     TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  state_t                  state_q, state_d;
  logic                    dmem_req_q, dmem_req_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]       dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]       dmem_wdata_q, dmem_wdata_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic [DATA_W-1:0]       read_data_q, read_data_d;
  logic [DATA_W-1:0]       alu_result_q, alu_result_d;
  logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic                    mem_to_reg_q, mem_to_reg_d;
  logic                    reg_write_q, reg_write_d;
  logic                    memop_s;
  logic                    timeout_s;

  assign memop_s = MemReadin | MemWritein;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;

  // Wait counter: zero outside WAIT, counts ack-less WAIT cycles, flags the abort cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_s  = 1'b0;
    if (state_q == S_WAIT) begin
      if (!dmem_ack) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if ((wait_cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES)) begin
          timeout_s = 1'b1;
        end else begin
          timeout_s = 1'b0;
        end
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = 8'd0;
    end
    mem_err_d = mem_err_q | timeout_s;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_cfg_s;

  assign timeout_s    = 1'b0;
  assign mem_err      = 1'b0;
  assign unused_cfg_s = ^8'(TIMEOUT_CYCLES);
`endif

  // State register plus all registered memory-port and MEM/WB fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= ZERO_D;
      dmem_wdata_q <= ZERO_D;
      hold_q       <= ZERO_D;
      read_data_q  <= ZERO_D;
      alu_result_q <= ZERO_D;
      wb_addr_q    <= ZERO_R;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      hold_q       <= hold_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      wb_addr_q    <= wb_addr_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held memop cannot re-issue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (memop_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_ack || timeout_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: stall, memory request and MEM/WB loading per state.
  always_comb begin
    stall        = 1'b0;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    hold_d       = hold_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    wb_addr_d    = wb_addr_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    case (state_q)
      S_IDLE: begin
        if (memop_s) begin
          stall        = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = MemWritein;
          dmem_addr_d  = ALUResultin;
          dmem_wdata_d = RtDatain;
          read_data_d  = ZERO_D;
          alu_result_d = ZERO_D;
          wb_addr_d    = ZERO_R;
          mem_to_reg_d = 1'b0;
          reg_write_d  = 1'b0;
        end else begin
          stall        = 1'b0;
          read_data_d  = ZERO_D;
          alu_result_d = ALUResultin;
          wb_addr_d    = regwriteAddressin;
          mem_to_reg_d = MemtoRegin;
          reg_write_d  = RegWritein;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          hold_d     = dmem_we_q ? ZERO_D : dmem_rdata;
        end else if (timeout_s) begin
          dmem_req_d = 1'b0;
          hold_d     = TIMEOUT_DATA;
        end else begin
          dmem_req_d = dmem_req_q;
          hold_d     = hold_q;
        end
      end
      S_DONE: begin
        stall        = 1'b0;
        read_data_d  = hold_q;
        alu_result_d = ALUResultin;
        wb_addr_d    = regwriteAddressin;
        mem_to_reg_d = MemtoRegin;
        reg_write_d  = RegWritein;
      end
      default: begin
        stall      = 1'b0;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  assign dmem_req        = dmem_req_q;
  assign dmem_we         = dmem_we_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_wdata      = dmem_wdata_q;
  assign ReadData        = read_data_q;
  assign ALUResult       = alu_result_q;
  assign regwriteAddress = wb_addr_q;
  assign MemtoReg        = mem_to_reg_q;
  assign RegWrite        = reg_write_q;
  assign pcSrc           = Branchin & ZeroFlagin;
  assign BranchAddress   = BranchAddressin;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed spec scenarios plus random instruction mix
// checked against a per-instruction transaction model (stall length, port values, MEM/WB result).
module tb_mem_access_stage;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ALUResultin, RtDatain, BranchAddressin;
  logic [AW-1:0] regwriteAddressin;
  logic          ZeroFlagin, Branchin, MemtoRegin, RegWritein, MemReadin, MemWritein;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          stall, pcSrc, MemtoReg, RegWrite, mem_err;
  logic [DW-1:0] BranchAddress, ReadData, ALUResult;
  logic [AW-1:0] regwriteAddress;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .ALUResultin(ALUResultin), .RtDatain(RtDatain), .regwriteAddressin(regwriteAddressin),
    .BranchAddressin(BranchAddressin), .ZeroFlagin(ZeroFlagin), .Branchin(Branchin),
    .MemtoRegin(MemtoRegin), .RegWritein(RegWritein), .MemReadin(MemReadin), .MemWritein(MemWritein),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .pcSrc(pcSrc),
    .BranchAddress(BranchAddress), .ReadData(ReadData), .ALUResult(ALUResult),
    .regwriteAddress(regwriteAddress), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ALUResultin = 32'd0; RtDatain = 32'd0; BranchAddressin = 32'd0; regwriteAddressin = 5'd0;
    ZeroFlagin = 1'b0; Branchin = 1'b0; MemtoRegin = 1'b0; RegWritein = 1'b0;
    MemReadin = 1'b0; MemWritein = 1'b0;
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_rdata"}, ReadData, 32'd0);
    chk({tag, "_alu"}, ALUResult, 32'd0);
    chk({tag, "_rd"}, {27'd0, regwriteAddress}, 32'd0);
    chk({tag, "_m2r"}, {31'd0, MemtoReg}, 32'd0);
    chk({tag, "_rw"}, {31'd0, RegWrite}, 32'd0);
    chk({tag, "_err"}, {31'd0, mem_err}, 32'd0);
  endtask

  // One instruction through the stage; ack_delay = WAIT cycles before the ack cycle.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] ba,
                       input logic [4:0] rd, input logic zero, input logic br, input logic m2r,
                       input logic rw, input logic mr, input logic mw,
                       input int ack_delay, input logic [31:0] rdata);
    logic        memop;
    logic        tmo;
    int          wait_cycles;
    logic [31:0] exp_read;
    ALUResultin = alu; RtDatain = rt; BranchAddressin = ba; regwriteAddressin = rd;
    ZeroFlagin = zero; Branchin = br; MemtoRegin = m2r; RegWritein = rw;
    MemReadin = mr; MemWritein = mw;
    memop = mr | mw;
    tmo = TMO_EN && memop && (ack_delay >= TMO);
    if (!memop || mw)  exp_read = 32'd0;
    else if (tmo)      exp_read = 32'hDEADBEEF;
    else               exp_read = rdata;
    #1;
    chk("pcsrc", {31'd0, pcSrc}, {31'd0, br & zero});
    chk("branch_addr", BranchAddress, ba);
    if (!memop) begin
      chk("stall_alu", {31'd0, stall}, 32'd0);
      tick();
    end else begin
      chk("stall_issue", {31'd0, stall}, 32'd1);
      chk("req_before_issue", {31'd0, dmem_req}, 32'd0);
      tick();
      chk("req_issued", {31'd0, dmem_req}, 32'd1);
      chk("we_issued", {31'd0, dmem_we}, {31'd0, mw});
      chk("addr_issued", dmem_addr, alu);
      chk("wdata_issued", dmem_wdata, rt);
      chk("bubble_m2r", {31'd0, MemtoReg}, 32'd0);
      wait_cycles = tmo ? TMO : ack_delay + 1;
      for (int k = 0; k < wait_cycles; k++) begin
        chk("stall_wait", {31'd0, stall}, 32'd1);
        chk("req_held", {31'd0, dmem_req}, 32'd1);
        chk("addr_held", dmem_addr, alu);
        if (!tmo && k == ack_delay) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        tick();
        dmem_ack = 1'b0;
        chk("bubble_rw", {31'd0, RegWrite}, 32'd0);
      end
      if (tmo) exp_err = 1'b1;
      chk("stall_done", {31'd0, stall}, 32'd0);
      chk("req_dropped", {31'd0, dmem_req}, 32'd0);
      chk("err_done", {31'd0, mem_err}, {31'd0, exp_err});
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      tick();
      dmem_ack = 1'b0;
      chk("no_reissue", {31'd0, dmem_req}, 32'd0);
    end
    chk("wb_rw", {31'd0, RegWrite}, {31'd0, rw});
    chk("wb_m2r", {31'd0, MemtoReg}, {31'd0, m2r});
    chk("wb_alu", ALUResult, alu);
    chk("wb_rd", {27'd0, regwriteAddress}, {27'd0, rd});
    chk("wb_rdata", ReadData, exp_read);
    chk("wb_err", {31'd0, mem_err}, {31'd0, exp_err});
  endtask

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive_nop();
    tick(); tick();
    chk_wb_zero("reset");
    chk("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    // Directed scenarios
    do_op(32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    do_op(32'h40, 32'h0, 32'h100, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'hCAFEF00D);
    do_op(32'h80, 32'h55AA, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'hFFFFFFFF);
    do_op(32'h44, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h11111111);
    do_op(32'h48, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 32'h22222222);
    do_op(32'h8C, 32'h77, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h33333333);
    do_op(32'hFFFFFFFF, 32'h0, 32'hABCD0000, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);

    // Random instruction mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic mr, mw;
      kind = $urandom_range(0, 3);
      mr = (kind == 1) || (kind == 3);
      mw = (kind == 2) || (kind == 3);
      do_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), mr, mw, $urandom_range(0, 5), $urandom);
    end

    // Reset in WAIT with a simultaneous ack, then a stray ack
    drive_nop();
    MemReadin = 1'b1; ALUResultin = 32'h200; RegWritein = 1'b1; regwriteAddressin = 5'd9;
    tick(); tick();
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    reset = 1'b0; dmem_ack = 1'b0;
    drive_nop();
    exp_err = 1'b0;
    #1;
    chk_wb_zero("rst_wait");
    chk("rst_wait_stall", {31'd0, stall}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h87654321;
    tick();
    dmem_ack = 1'b0;
    chk("stray_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_rdata", ReadData, 32'd0);
    chk("stray_rw", {31'd0, RegWrite}, 32'd0);
    do_op(32'h300, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'hA5A5A5A5);

`ifdef MEM_TIMEOUT_EN
    // Timeout with no ack, then ack on the last permitted WAIT cycle
    do_op(32'h500, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, TMO, 32'h0);
    chk("tmo_sticky", {31'd0, mem_err}, 32'd1);
    drive_nop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 1'b0;
    chk("tmo_cleared", {31'd0, mem_err}, 32'd0);
    do_op(32'h504, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, TMO - 1, 32'h0BADF00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
